// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters; owns the V/Z/N flags.
// Grant is same-cycle, the result lands in the response slot one cycle later, and a full slot blocks only its own requester.
module alu_arbiter #(
  parameter int W          = 16,
  parameter int PRIO_RESET = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         r0_valid,
  output logic         r0_ready,
  input  logic [2:0]   r0_ctrl,
  input  logic [W-1:0] r0_src0,
  input  logic [W-1:0] r0_src1,
  input  logic [3:0]   r0_shamt,
  input  logic         r0_setf,
  input  logic         r1_valid,
  output logic         r1_ready,
  input  logic [2:0]   r1_ctrl,
  input  logic [W-1:0] r1_src0,
  input  logic [W-1:0] r1_src1,
  input  logic [3:0]   r1_shamt,
  input  logic         r1_setf,
  output logic [2:0]   alu_ctrl,
  output logic [W-1:0] alu_src0,
  output logic [W-1:0] alu_src1,
  output logic [3:0]   alu_shamt,
  input  logic [W-1:0] alu_dst,
  input  logic         alu_ovf,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_data,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_data,
  output logic         flag_v,
  output logic         flag_z,
  output logic         flag_n
);

  // last_q = 1 means requester 1 won most recently, so requester 0 wins the next contention
  localparam logic LAST_RST = (PRIO_RESET == 0);

  logic         elig0, elig1, gnt0, gnt1, gnt_any, gnt_setf, gnt_arith;
  logic         last_q, last_d;
  logic         rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [W-1:0] rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
  logic         flag_v_q, flag_v_d, flag_z_q, flag_z_d, flag_n_q, flag_n_d;

  always_comb begin
    elig0     = r0_valid && (!rsp0_valid_q || rsp0_ready);
    elig1     = r1_valid && (!rsp1_valid_q || rsp1_ready);
    gnt0      = rst_n && elig0 && (!elig1 || last_q);
    gnt1      = rst_n && elig1 && (!elig0 || !last_q);
    gnt_any   = gnt0 || gnt1;

    alu_ctrl  = 3'd0;
    alu_src0  = '0;
    alu_src1  = '0;
    alu_shamt = 4'd0;
    gnt_setf  = 1'b0;
    if (gnt0) begin
      alu_ctrl  = r0_ctrl;
      alu_src0  = r0_src0;
      alu_src1  = r0_src1;
      alu_shamt = r0_shamt;
      gnt_setf  = r0_setf;
    end else if (gnt1) begin
      alu_ctrl  = r1_ctrl;
      alu_src0  = r1_src0;
      alu_src1  = r1_src1;
      alu_shamt = r1_shamt;
      gnt_setf  = r1_setf;
    end
    gnt_arith = (alu_ctrl == 3'b000) || (alu_ctrl == 3'b010);
  end

  always_comb begin
    last_d       = last_q;
    rsp0_valid_d = rsp0_valid_q && !rsp0_ready;
    rsp1_valid_d = rsp1_valid_q && !rsp1_ready;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    flag_v_d     = flag_v_q;
    flag_z_d     = flag_z_q;
    flag_n_d     = flag_n_q;

    if (gnt_any) last_d = gnt1;
    // A capture wins over a same-cycle drain, so the slot stays full with fresh data
    if (gnt0) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = alu_dst;
    end
    if (gnt1) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = alu_dst;
    end
    if (gnt_any && gnt_setf) begin
      flag_z_d = (alu_dst == '0);
      if (gnt_arith) begin
        flag_v_d = alu_ovf;
        flag_n_d = alu_dst[W-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q       <= LAST_RST;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      flag_v_q     <= 1'b0;
      flag_z_q     <= 1'b0;
      flag_n_q     <= 1'b0;
    end else begin
      last_q       <= last_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
      flag_v_q     <= flag_v_d;
      flag_z_q     <= flag_z_d;
      flag_n_q     <= flag_n_d;
    end
  end

  assign r0_ready   = gnt0;
  assign r1_ready   = gnt1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign flag_v     = flag_v_q;
  assign flag_z     = flag_z_q;
  assign flag_n     = flag_n_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a saturating ALU model closes the loop, and a slot/flag scoreboard predicts every cycle.
module tb_alu_arbiter;
  localparam int W    = 16;
  localparam int PRIO = 0;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           v     [2];
  logic [2:0]     ctrl  [2];
  logic [W-1:0]   s0    [2];
  logic [W-1:0]   s1    [2];
  logic [3:0]     sh    [2];
  logic           setf  [2];
  logic           rr    [2];
  logic           r0_ready, r1_ready, rsp0_valid, rsp1_valid;
  logic [W-1:0]   rsp0_data, rsp1_data;
  logic           flag_v, flag_z, flag_n;
  logic [2:0]     alu_ctrl;
  logic [W-1:0]   alu_src0, alu_src1, alu_dst;
  logic [3:0]     alu_shamt;
  logic           alu_ovf;

  int checks = 0;
  int errors = 0;

  // Scoreboard state
  bit           m_vld [2];
  logic [W-1:0] m_dat [2];
  int           m_last;
  bit           m_v, m_z, m_n;
  int           last_g;
  int           seq [6];

  always #5 clk = ~clk;

  // Shared ALU: add/sub saturate and flag overflow; returns {ovf, dst}
  function automatic logic [W:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [3:0] n);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      3'd0, 3'd2: begin
        r = (op == 3'd0) ? sa + sb : sa - sb;
        if (r > 32767)       return {1'b1, 16'h7FFF};
        else if (r < -32768) return {1'b1, 16'h8000};
        else                 return {1'b0, r[15:0]};
      end
      3'd1:    return {1'b0, b[7:0], a[7:0]};
      3'd3:    return {1'b0, a & b};
      3'd4:    return {1'b0, ~(a | b)};
      3'd5:    return {1'b0, a << n};
      3'd6:    return {1'b0, a >> n};
      default: return {1'b0, $signed(a) >>> n};
    endcase
  endfunction

  assign {alu_ovf, alu_dst} = ref_alu(alu_ctrl, alu_src0, alu_src1, alu_shamt);

  alu_arbiter #(.W(W), .PRIO_RESET(PRIO)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(v[0]), .r0_ready(r0_ready), .r0_ctrl(ctrl[0]), .r0_src0(s0[0]),
    .r0_src1(s1[0]), .r0_shamt(sh[0]), .r0_setf(setf[0]),
    .r1_valid(v[1]), .r1_ready(r1_ready), .r1_ctrl(ctrl[1]), .r1_src0(s0[1]),
    .r1_src1(s1[1]), .r1_shamt(sh[1]), .r1_setf(setf[1]),
    .alu_ctrl(alu_ctrl), .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_shamt(alu_shamt),
    .alu_dst(alu_dst), .alu_ovf(alu_ovf),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rr[0]), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rr[1]), .rsp1_data(rsp1_data),
    .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vld[0] = 0; m_vld[1] = 0;
    m_dat[0] = '0; m_dat[1] = '0;
    m_last = 1 - PRIO;
    m_v = 0; m_z = 0; m_n = 0;
  endtask

  task automatic set_req(input int i, input logic vv, input logic [2:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [3:0] n, input logic sf);
    v[i] = vv; ctrl[i] = c; s0[i] = a; s1[i] = b; sh[i] = n; setf[i] = sf;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge
  task automatic cycle();
    int g;
    bit e0, e1;
    logic [W:0] r;
    r = '0;
    #1;
    e0 = v[0] && (!m_vld[0] || rr[0]);
    e1 = v[1] && (!m_vld[1] || rr[1]);
    if (e0 && e1)  g = 1 - m_last;
    else if (e0)   g = 0;
    else if (e1)   g = 1;
    else           g = -1;
    chk("r0_ready", 32'(r0_ready), 32'(g == 0));
    chk("r1_ready", 32'(r1_ready), 32'(g == 1));
    if (g >= 0) begin
      chk("alu_ctrl", 32'(alu_ctrl), 32'(ctrl[g]));
      chk("alu_src0", 32'(alu_src0), 32'(s0[g]));
      chk("alu_src1", 32'(alu_src1), 32'(s1[g]));
      chk("alu_shamt", 32'(alu_shamt), 32'(sh[g]));
      r = ref_alu(ctrl[g], s0[g], s1[g], sh[g]);
    end else begin
      chk("alu_idle", {alu_ctrl, alu_shamt, alu_src0, alu_src1[8:0]} == '0 ? 32'd0 : 32'd1, 32'd0);
      chk("alu_idle_src1", 32'(alu_src1), 32'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (g == i) begin
        m_vld[i] = 1;
        m_dat[i] = r[W-1:0];
      end else if (m_vld[i] && rr[i]) begin
        m_vld[i] = 0;
      end
    end
    if (g >= 0) begin
      m_last = g;
      if (setf[g]) begin
        m_z = (r[W-1:0] == '0);
        if (ctrl[g] == 3'd0 || ctrl[g] == 3'd2) begin
          m_v = r[W];
          m_n = r[W-1];
        end
      end
    end
    last_g = g;
    chk("rsp0_valid", 32'(rsp0_valid), 32'(m_vld[0]));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(m_vld[1]));
    chk("rsp0_data", 32'(rsp0_data), 32'(m_dat[0]));
    chk("rsp1_data", 32'(rsp1_data), 32'(m_dat[1]));
    chk("flags_vzn", 32'({flag_v, flag_z, flag_n}), 32'({m_v, m_z, m_n}));
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] held;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_req(i, 1'b1, 3'd0, 16'h1111, 16'h2222, 4'd0, 1'b1);
      rr[i] = 1'b1;
    end
    model_reset();
    #2;
    // Reset state, with valids high to confirm no grant while in reset
    chk("rst_r0_ready", 32'(r0_ready), 32'd0);
    chk("rst_r1_ready", 32'(r1_ready), 32'd0);
    chk("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    chk("rst_rsp_data", 32'({rsp0_data, rsp1_data}), 32'd0);
    chk("rst_flags", 32'({flag_v, flag_z, flag_n}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention: alternate starting from PRIO, each slot holds its own result
    for (int k = 0; k < 6; k++) begin
      set_req(0, 1'b1, 3'(k % 8), 16'(16'h0100 + k), 16'h0030, 4'(k), 1'b0);
      set_req(1, 1'b1, 3'((k + 3) % 8), 16'(16'hF000 - k), 16'h0F0F, 4'(k + 1), 1'b0);
      cycle();
      seq[k] = last_g;
    end
    for (int k = 0; k < 6; k++) chk($sformatf("contend_grant%0d", k), 32'(seq[k]), 32'(k % 2));

    // Single requester add
    set_req(1, 1'b0, 3'd0, '0, '0, 4'd0, 1'b0);
    set_req(0, 1'b1, 3'd0, 16'h0003, 16'h0004, 4'd0, 1'b1);
    cycle();
    chk("single_grant", 32'(last_g), 32'd0);
    chk("single_data", 32'(rsp0_data), 32'h0007);
    chk("single_flags", 32'({flag_v, flag_z, flag_n}), 32'd0);

    // Backpressure on slot 0 while both keep requesting
    set_req(0, 1'b1, 3'd3, 16'h00FF, 16'h0F0F, 4'd0, 1'b0);
    cycle();
    held = rsp0_data;
    rr[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1'b1, 3'd0, 16'h0001, 16'h0001, 4'd0, 1'b0);
      set_req(1, 1'b1, 3'd6, 16'h8000, 16'h0000, 4'(k), 1'b0);
      cycle();
      chk("bp_r1_granted", 32'(last_g), 32'd1);
      chk("bp_data_stable", 32'(rsp0_data), 32'(held));
    end
    rr[0] = 1'b1;
    set_req(0, 1'b1, 3'd0, 16'h0010, 16'h0020, 4'd0, 1'b0);
    cycle();
    chk("bp_release_grant", 32'(last_g), 32'd0);
    chk("bp_release_data", 32'({rsp0_valid, rsp0_data}), 32'h1_0030);

    // Flag sequence
    set_req(1, 1'b0, 3'd0, '0, '0, 4'd0, 1'b0);
    set_req(0, 1'b1, 3'd2, 16'h0005, 16'h0005, 4'd0, 1'b1);
    cycle();
    chk("flag_sub_zero", 32'({flag_v, flag_z, flag_n}), 32'b010);
    set_req(0, 1'b1, 3'd3, 16'h8000, 16'h8000, 4'd0, 1'b1);
    cycle();
    chk("flag_and_neg", 32'({flag_v, flag_z, flag_n}), 32'b000);
    set_req(0, 1'b1, 3'd0, 16'h4000, 16'h4000, 4'd0, 1'b1);
    cycle();
    chk("flag_add_sat", 32'({flag_v, flag_z, flag_n, rsp0_data}), 32'h4_7FFF);
    set_req(0, 1'b1, 3'd2, 16'h0001, 16'h0001, 4'd0, 1'b0);
    cycle();
    chk("flag_nosetf", 32'({flag_v, flag_z, flag_n}), 32'b100);

    // Idle
    set_req(0, 1'b0, 3'd5, 16'hABCD, 16'h1234, 4'd3, 1'b1);
    cycle();

    // Asynchronous reset with a pending, blocked response on slot 1
    rr[1] = 1'b0;
    set_req(1, 1'b1, 3'd4, 16'h0000, 16'h0000, 4'd0, 1'b1);
    cycle();
    set_req(1, 1'b0, 3'd0, '0, '0, 4'd0, 1'b0);
    chk("pre_rst_rsp1", 32'({rsp1_valid, flag_v}), 32'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("async_flags", 32'({flag_v, flag_z, flag_n}), 32'd0);
    model_reset();
    rr[1] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b1, 3'd1, 16'h00AA, 16'h0055, 4'd0, 1'b0);
    set_req(1, 1'b1, 3'd7, 16'h8001, 16'h0000, 4'd4, 1'b1);
    cycle();
    chk("prio_after_reset", 32'(last_g), 32'(PRIO));

    // Randomized traffic against the scoreboard
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        set_req(i, 1'($urandom_range(3) != 0), 3'($urandom), 16'($urandom), 16'($urandom),
                4'($urandom), 1'($urandom));
        rr[i] = 1'($urandom_range(3) != 0);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
